regfile_access_ctrl: RTL and testbench

//  Initiator side of the 32x32 register file (2 read ports, 1 write port).

---
 rtl/regfile_access_ctrl_pkg.sv | 24 ++
 rtl/regfile_wb_fifo.sv | 76 +++++++
 rtl/regfile_access_ctrl.sv | 105 ++++++++++
 tb/tb_regfile_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared widths and fetch FSM encoding for the register-file access controller.
package regfile_access_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // r0 is hardwired to zero; a pending writeback overrides the stale regfile value.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  hit,
    input logic [DATA_W-1:0]     fifo_data,
    input logic [DATA_W-1:0]     rf_data
  );
    if (addr == '0) return '0;
    if (hit)        return fifo_data;
    return rf_data;
  endfunction
endpackage

// File: rtl/regfile_wb_fifo.sv
// Writeback FIFO with two combinational search ports returning the youngest matching entry.
module regfile_wb_fifo
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic                             push,
  input  logic [REG_ADDR_W-1:0]            push_reg,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic                             empty,
  output logic                             full,
  output logic [REG_ADDR_W-1:0]            head_reg,
  output logic [DATA_W-1:0]                head_data,
  input  logic [1:0][REG_ADDR_W-1:0]       search_addr,
  output logic [1:0]                       search_hit,
  output logic [1:0][DATA_W-1:0]           search_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [REG_ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0]     data_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W:0]        count_reg;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign head_reg  = empty ? '0 : reg_mem[rd_ptr_reg];
  assign head_data = empty ? '0 : data_mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    if (push) begin
      reg_mem[wr_ptr_reg]  <= push_reg;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_search
    logic              hit_g;
    logic [DATA_W-1:0] data_g;
    always_comb begin
      hit_g  = 1'b0;
      data_g = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (((PTR_W+1)'(i) < count_reg) &&
            (reg_mem[rd_ptr_reg + PTR_W'(i)] == search_addr[gi])) begin
          hit_g  = 1'b1;
          data_g = data_mem[rd_ptr_reg + PTR_W'(i)];
        end
      end
    end
    assign search_hit[gi]  = hit_g;
    assign search_data[gi] = data_g;
  end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand fetch FSM and writeback queue driving a 2R/1W register file, with write bypass.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  output logic                  opnd_valid,
  input  logic                  opnd_ready,
  output logic [DATA_W-1:0]     opnd_a,
  output logic [DATA_W-1:0]     opnd_b,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_drain_en,
  output logic [REG_ADDR_W-1:0] ctrl_readRegA,
  output logic [REG_ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0]     data_readRegA,
  input  logic [DATA_W-1:0]     data_readRegB,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
);
  fetch_state_t state_reg, state_next;

  logic                        issue_fire;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        wb_push;
  logic                        wb_pop;
  logic [1:0][REG_ADDR_W-1:0]  search_addr;
  logic [1:0]                  search_hit;
  logic [1:0][DATA_W-1:0]      search_data;

  assign wb_pop           = !fifo_empty && wb_drain_en;
  assign ctrl_writeEnable = wb_pop;
  assign wb_ready         = !fifo_full || wb_pop;
  // r0 writebacks complete the handshake but never enter the queue.
  assign wb_push          = wb_valid && wb_ready && (wb_reg != '0);
  assign search_addr      = {ctrl_readRegB, ctrl_readRegA};

  regfile_wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .push        (wb_push),
    .push_reg    (wb_reg),
    .push_data   (wb_data),
    .pop         (wb_pop),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .head_reg    (ctrl_writeReg),
    .head_data   (data_writeReg),
    .search_addr (search_addr),
    .search_hit  (search_hit),
    .search_data (search_data)
  );

  always_comb begin
    state_next  = state_reg;
    issue_ready = 1'b0;
    opnd_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) state_next = READ;
      end
      READ: state_next = RESP;
      RESP: begin
        opnd_valid  = 1'b1;
        issue_ready = opnd_ready;
        if (opnd_ready) state_next = issue_valid ? READ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign issue_fire = issue_valid && issue_ready;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_reg     <= IDLE;
      ctrl_readRegA <= '0;
      ctrl_readRegB <= '0;
      opnd_a        <= '0;
      opnd_b        <= '0;
    end else begin
      state_reg <= state_next;
      if (issue_fire) begin
        ctrl_readRegA <= issue_rs;
        ctrl_readRegB <= issue_rt;
      end
      // The queue still holds a head committing at this edge, so it is bypassed too.
      if (state_reg == READ) begin
        opnd_a <= pick_operand(ctrl_readRegA, search_hit[0], search_data[0], data_readRegA);
        opnd_b <= pick_operand(ctrl_readRegB, search_hit[1], search_data[1], data_readRegB);
      end
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench: behavioural 32x32 regfile plus per-feature scenario tasks.
module tb_regfile_access_ctrl;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs, issue_rt;
  logic        opnd_valid, opnd_ready;
  logic [31:0] opnd_a, opnd_b;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_drain_en;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [31:0] rf_model [32];
  logic [36:0] wlog [$];

  always #5 clock = ~clock;

  regfile_access_ctrl #(.WB_DEPTH(4)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_rs         (issue_rs),
    .issue_rt         (issue_rt),
    .opnd_valid       (opnd_valid),
    .opnd_ready       (opnd_ready),
    .opnd_a           (opnd_a),
    .opnd_b           (opnd_b),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .wb_drain_en      (wb_drain_en),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  assign data_readRegA = rf_model[ctrl_readRegA];
  assign data_readRegB = rf_model[ctrl_readRegB];

  always @(posedge clock) begin
    if (ctrl_writeEnable) begin
      wlog.push_back({ctrl_writeReg, data_writeReg});
      if (ctrl_writeReg != 5'd0) rf_model[ctrl_writeReg] <= data_writeReg;
    end
  end

  task automatic wb_push(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
    @(posedge clock); #1;
    wb_valid = 1'b0;
  endtask

  // Issue from IDLE; returns one cycle after capture (state RESP).
  task automatic do_fetch(input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; issue_rs = rs; issue_rt = rt;
    @(posedge clock); #1;
    issue_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic consume();
    opnd_ready = 1'b1;
    @(posedge clock); #1;
    opnd_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    check_cnt++; if (opnd_valid !== 1'b0) $display("FAIL rst_opnd_valid: got %b expected 0", opnd_valid); else pass_cnt++;
    check_cnt++; if (issue_ready !== 1'b1) $display("FAIL rst_issue_ready: got %b expected 1", issue_ready); else pass_cnt++;
    check_cnt++; if (opnd_a !== 32'd0 || opnd_b !== 32'd0) $display("FAIL rst_opnd: got %h/%h expected 0/0", opnd_a, opnd_b); else pass_cnt++;
    check_cnt++; if (ctrl_readRegA !== 5'd0 || ctrl_readRegB !== 5'd0) $display("FAIL rst_readreg: got %0d/%0d expected 0/0", ctrl_readRegA, ctrl_readRegB); else pass_cnt++;
    @(posedge clock); #1;
    wb_push(5'd1, 32'h11); wb_push(5'd2, 32'h22); wb_push(5'd3, 32'h33);
    ctrl_reset = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    issue_valid = 1'b1; issue_rs = 5'd9; issue_rt = 5'd10;
    @(posedge clock); #1;
    ctrl_reset = 1'b0; wb_valid = 1'b0; issue_valid = 1'b0; wb_drain_en = 1'b1;
    @(negedge clock);
    check_cnt++; if (ctrl_writeEnable !== 1'b0) $display("FAIL rst_q_we: got %b expected 0", ctrl_writeEnable); else pass_cnt++;
    check_cnt++; if (wb_ready !== 1'b1) $display("FAIL rst_q_wb_ready: got %b expected 1", wb_ready); else pass_cnt++;
    check_cnt++; if (ctrl_readRegA !== 5'd0) $display("FAIL rst_q_readRegA: got %0d expected 0", ctrl_readRegA); else pass_cnt++;
    repeat (3) @(posedge clock);
    #1;
    check_cnt++; if (opnd_valid !== 1'b0) $display("FAIL rst_q_opnd_valid: got %b expected 0", opnd_valid); else pass_cnt++;
    check_cnt++; if (wlog.size() !== 0) $display("FAIL rst_q_stale_writes: got %0d writes expected 0", wlog.size()); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_bypass_drain();
    wb_drain_en = 1'b1; wlog.delete();
    wb_push(5'd5, 32'hDEADBEEF);
    issue_valid = 1'b1; issue_rs = 5'd5; issue_rt = 5'd0;
    @(posedge clock); #1;
    issue_valid = 1'b0;
    @(negedge clock);
    check_cnt++; if (opnd_valid !== 1'b0) $display("FAIL t2_valid_early: got %b expected 0", opnd_valid); else pass_cnt++;
    check_cnt++; if (ctrl_readRegA !== 5'd5) $display("FAIL t2_readRegA: got %0d expected 5", ctrl_readRegA); else pass_cnt++;
    @(posedge clock); #1;
    check_cnt++; if (opnd_valid !== 1'b1) $display("FAIL t2_valid: got %b expected 1", opnd_valid); else pass_cnt++;
    check_cnt++; if (opnd_a !== 32'hDEADBEEF) $display("FAIL t2_opnd_a: got %h expected deadbeef", opnd_a); else pass_cnt++;
    check_cnt++; if (opnd_b !== 32'd0) $display("FAIL t2_opnd_b: got %h expected 0", opnd_b); else pass_cnt++;
    check_cnt++; if (wlog.size() !== 1 || wlog[0] !== {5'd5, 32'hDEADBEEF}) $display("FAIL t2_write: got %0d writes expected 1 to r5", wlog.size()); else pass_cnt++;
    consume();
    check_cnt++; if (opnd_valid !== 1'b0) $display("FAIL t2_consumed: got %b expected 0", opnd_valid); else pass_cnt++;
    $display("test_bypass_drain done");
  endtask

  task automatic test_commit_bypass();
    wb_drain_en = 1'b0;
    wb_push(5'd13, 32'h55);
    issue_valid = 1'b1; issue_rs = 5'd13; issue_rt = 5'd13;
    @(posedge clock); #1;
    issue_valid = 1'b0; wb_drain_en = 1'b1;
    @(posedge clock); #1;
    wb_drain_en = 1'b0;
    check_cnt++; if (opnd_a !== 32'h55 || opnd_b !== 32'h55) $display("FAIL commit_bypass: got %h/%h expected 55/55", opnd_a, opnd_b); else pass_cnt++;
    consume();
    $display("test_commit_bypass done");
  endtask

  task automatic test_youngest();
    wb_drain_en = 1'b0;
    wb_push(5'd7, 32'd1); wb_push(5'd7, 32'd2); wb_push(5'd7, 32'd3);
    do_fetch(5'd7, 5'd5);
    check_cnt++; if (opnd_a !== 32'd3) $display("FAIL t3_youngest: got %h expected 3", opnd_a); else pass_cnt++;
    check_cnt++; if (opnd_b !== 32'hDEADBEEF) $display("FAIL t3_rf_read: got %h expected deadbeef", opnd_b); else pass_cnt++;
    consume();
    wlog.delete(); wb_drain_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_cnt++; if (wlog.size() !== 3) $display("FAIL t3_write_count: got %0d expected 3", wlog.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      check_cnt++;
      if (wlog[i] !== {5'd7, 32'(i + 1)}) $display("FAIL t3_write_order: got %h expected %h", wlog[i], {5'd7, 32'(i + 1)}); else pass_cnt++;
    end
    $display("test_youngest done");
  endtask

  task automatic test_full();
    wlog.delete(); wb_drain_en = 1'b0;
    for (int i = 0; i < 4; i++) wb_push(5'(8 + i), 32'(32'h80 + i));
    @(negedge clock);
    check_cnt++; if (wb_ready !== 1'b0) $display("FAIL t4_full_ready: got %b expected 0", wb_ready); else pass_cnt++;
    wb_drain_en = 1'b1; wb_valid = 1'b1; wb_reg = 5'd12; wb_data = 32'h8C;
    #1;
    check_cnt++; if (wb_ready !== 1'b1 || ctrl_writeEnable !== 1'b1) $display("FAIL t4_pushpop: got ready=%b we=%b expected 1/1", wb_ready, ctrl_writeEnable); else pass_cnt++;
    check_cnt++; if (ctrl_writeReg !== 5'd8) $display("FAIL t4_head: got %0d expected 8", ctrl_writeReg); else pass_cnt++;
    @(posedge clock); #1;
    wb_valid = 1'b0; wb_drain_en = 1'b0;
    @(negedge clock);
    check_cnt++; if (wb_ready !== 1'b0) $display("FAIL t4_count_kept: got ready %b expected 0", wb_ready); else pass_cnt++;
    check_cnt++; if (ctrl_writeReg !== 5'd9 || ctrl_writeEnable !== 1'b0) $display("FAIL t4_head2: got r%0d we=%b expected r9 we=0", ctrl_writeReg, ctrl_writeEnable); else pass_cnt++;
    wb_drain_en = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check_cnt++; if (wlog.size() !== 5) $display("FAIL t4_writes: got %0d expected 5", wlog.size()); else pass_cnt++;
    check_cnt++; if (wlog.size() == 5 && (wlog[0] !== {5'd8, 32'h80} || wlog[4] !== {5'd12, 32'h8C})) $display("FAIL t4_order: got %h..%h expected %h..%h", wlog[0], wlog[4], {5'd8, 32'h80}, {5'd12, 32'h8C}); else pass_cnt++;
    check_cnt++; if (ctrl_writeEnable !== 1'b0 || data_writeReg !== 32'd0) $display("FAIL t4_empty: got we=%b data=%h expected 0/0", ctrl_writeEnable, data_writeReg); else pass_cnt++;
    $display("test_full done");
  endtask

  task automatic test_r0();
    wlog.delete(); wb_drain_en = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h1234;
    #1;
    check_cnt++; if (wb_ready !== 1'b1) $display("FAIL t5_r0_ready: got %b expected 1", wb_ready); else pass_cnt++;
    @(posedge clock); #1;
    wb_valid = 1'b0;
    @(negedge clock);
    check_cnt++; if (ctrl_writeEnable !== 1'b0) $display("FAIL t5_r0_we: got %b expected 0", ctrl_writeEnable); else pass_cnt++;
    do_fetch(5'd0, 5'd7);
    check_cnt++; if (opnd_a !== 32'd0 || opnd_b !== 32'd3) $display("FAIL t5_opnd: got %h/%h expected 0/3", opnd_a, opnd_b); else pass_cnt++;
    consume();
    check_cnt++; if (wlog.size() !== 0) $display("FAIL t5_no_write: got %0d expected 0", wlog.size()); else pass_cnt++;
    $display("test_r0 done");
  endtask

  task automatic test_stall_back_to_back();
    wb_drain_en = 1'b1;
    do_fetch(5'd5, 5'd7);
    wb_push(5'd5, 32'hBBBB);
    issue_valid = 1'b1; issue_rs = 5'd8; issue_rt = 5'd9;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_cnt++;
      if (opnd_valid !== 1'b1 || opnd_a !== 32'hDEADBEEF || opnd_b !== 32'd3 || issue_ready !== 1'b0)
        $display("FAIL t6_stall: got v=%b a=%h b=%h ir=%b expected 1/deadbeef/3/0", opnd_valid, opnd_a, opnd_b, issue_ready);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    issue_rs = 5'd5; issue_rt = 5'd8; opnd_ready = 1'b1;
    #1;
    check_cnt++; if (issue_ready !== 1'b1) $display("FAIL t6_ready_follow: got %b expected 1", issue_ready); else pass_cnt++;
    @(posedge clock); #1;
    opnd_ready = 1'b0; issue_valid = 1'b0;
    @(negedge clock);
    check_cnt++; if (opnd_valid !== 1'b0 || ctrl_readRegA !== 5'd5) $display("FAIL t6_b2b_read: got v=%b rA=%0d expected 0/5", opnd_valid, ctrl_readRegA); else pass_cnt++;
    @(posedge clock); #1;
    check_cnt++; if (opnd_valid !== 1'b1 || opnd_a !== 32'hBBBB || opnd_b !== 32'h80) $display("FAIL t6_b2b_opnd: got v=%b %h/%h expected 1/bbbb/80", opnd_valid, opnd_a, opnd_b); else pass_cnt++;
    consume();
    $display("test_stall_back_to_back done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    ctrl_reset = 1'b1; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0;
    opnd_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; wb_drain_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    test_reset();
    test_bypass_drain();
    test_commit_bypass();
    test_youngest();
    test_full();
    test_r0();
    test_stall_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
